cordic_phase_gen: RTL and testbench

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/cordic_phase_lfsr.sv | 22 ++
 rtl/cordic_phase_gen.sv | 142 ++++++++++++++
 tb/tb_cordic_phase_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC phase generator: FSM states,
// quadrant codes and the pi/2 angle-scaling constant.
package cordic_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } phase_state_t;

  typedef enum logic [1:0] {
    QUARTER_0   = 2'd0,
    QUARTER_90  = 2'd1,
    QUARTER_180 = 2'd2,
    QUARTER_270 = 2'd3
  } quarter_t;

  // pi * 2^60, used to derive round(pi/2 * 2^(w-1)) without real arithmetic
  localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

  function automatic logic [63:0] calc_k(input int angle_width);
    logic [63:0] half_lsb;
    half_lsb = 64'd1 << (61 - angle_width);
    return (PI_Q60 + half_lsb) >> (62 - angle_width);
  endfunction

endpackage

// File: rtl/cordic_phase_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used as phase dither source.
module cordic_phase_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic feedback;
  assign feedback = value_o[15] ^ value_o[13] ^ value_o[12] ^ value_o[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      value_o <= SEED;
    end else if (step_i) begin
      value_o <= {value_o[14:0], feedback};
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator front-end for a CORDIC rotator: emits quadrant, scaled
// residual angle and delayed amplitude with 2-cycle latency.
// Optional phase dither is enabled by defining CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ANGLE_WIDTH = 16,
  parameter int PHASE_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run_i,
  input  logic [PHASE_WIDTH-1:0]        freq_word_i,
  input  logic                          freq_load_i,
  input  logic                          phase_clr_i,
  input  logic [PHASE_WIDTH-1:0]        phase_offset_i,
  input  logic signed [DATA_WIDTH:0]    amp_i,
  output logic signed [DATA_WIDTH:0]    x_o,
  output logic [ANGLE_WIDTH-1:0]        theta_o,
  output logic [1:0]                    quarter_o,
  output logic                          valid_o
);

  localparam int LOW_W = PHASE_WIDTH - 2 - ANGLE_WIDTH;
  localparam logic [ANGLE_WIDTH-1:0] K_CONST = ANGLE_WIDTH'(calc_k(ANGLE_WIDTH));

  phase_state_t               state_reg, state_next;
  logic [PHASE_WIDTH-1:0]     acc_reg, acc_next;
  logic [PHASE_WIDTH-1:0]     inc_reg;
  logic [PHASE_WIDTH-1:0]     phase_sample;
  logic                       run_cycle;

  assign run_cycle = (state_reg == ST_RUN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (run_i)  state_next = ST_RUN;
      ST_RUN:  if (!run_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A clear overrides the accumulate step in the same cycle
  always_comb begin
    acc_next = acc_reg;
    if (phase_clr_i) begin
      acc_next = phase_offset_i;
    end else if (run_cycle) begin
      acc_next = acc_reg + inc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      inc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      if (freq_load_i) inc_reg <= freq_word_i;
    end
  end

`ifdef CORDIC_PHASE_DITHER_EN
  logic [15:0]            lfsr_value;
  logic [PHASE_WIDTH-1:0] dither_add;

  cordic_phase_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_i  (run_cycle),
    .value_o (lfsr_value)
  );

  // Align the LFSR MSB just below the frac field
  generate
    if (LOW_W >= 16) begin : g_dither_wide
      assign dither_add = PHASE_WIDTH'(lfsr_value) << (LOW_W - 16);
    end else begin : g_dither_narrow
      assign dither_add = PHASE_WIDTH'(lfsr_value >> (16 - LOW_W));
    end
  endgenerate

  assign phase_sample = acc_reg + dither_add;
`else
  assign phase_sample = acc_reg;
`endif

  generate
    if (LOW_W > 0) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^phase_sample[LOW_W-1:0];
    end
  endgenerate

  logic                       valid_s1_reg;
  logic [1:0]                 quarter_s1_reg;
  logic [ANGLE_WIDTH-1:0]     frac_s1_reg;
  logic signed [DATA_WIDTH:0] amp_s1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1_reg   <= 1'b0;
      quarter_s1_reg <= '0;
      frac_s1_reg    <= '0;
      amp_s1_reg     <= '0;
    end else begin
      valid_s1_reg <= run_cycle;
      if (run_cycle) begin
        quarter_s1_reg <= phase_sample[PHASE_WIDTH-1 -: 2];
        frac_s1_reg    <= phase_sample[PHASE_WIDTH-3 -: ANGLE_WIDTH];
        amp_s1_reg     <= amp_i;
      end
    end
  end

  // frac < 2^W and K < 2^W, so the top half of the product is always < K
  logic [2*ANGLE_WIDTH-1:0] theta_prod;
  logic                     unused_prod;
  assign theta_prod  = {{ANGLE_WIDTH{1'b0}}, frac_s1_reg} * {{ANGLE_WIDTH{1'b0}}, K_CONST};
  assign unused_prod = ^theta_prod[ANGLE_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o   <= 1'b0;
      x_o       <= '0;
      theta_o   <= '0;
      quarter_o <= '0;
    end else begin
      valid_o <= valid_s1_reg;
      if (valid_s1_reg) begin
        x_o       <= amp_s1_reg;
        theta_o   <= theta_prod[2*ANGLE_WIDTH-1:ANGLE_WIDTH];
        quarter_o <= quarter_s1_reg;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed-vector bench for cordic_phase_gen (PHASE_WIDTH=32, ANGLE_WIDTH=16).
module tb_cordic_phase_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               run_i = 1'b0;
  logic [31:0]        freq_word_i = '0;
  logic               freq_load_i = 1'b0;
  logic               phase_clr_i = 1'b0;
  logic [31:0]        phase_offset_i = '0;
  logic signed [12:0] amp_i = '0;
  logic signed [12:0] x_o;
  logic [15:0]        theta_o;
  logic [1:0]         quarter_o;
  logic               valid_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [1:0]  exp_q [8];
  logic [15:0] exp_t [8];

  always #5 clk = ~clk;

  cordic_phase_gen #(
    .DATA_WIDTH  (12),
    .ANGLE_WIDTH (16),
    .PHASE_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_i          (run_i),
    .freq_word_i    (freq_word_i),
    .freq_load_i    (freq_load_i),
    .phase_clr_i    (phase_clr_i),
    .phase_offset_i (phase_offset_i),
    .amp_i          (amp_i),
    .x_o            (x_o),
    .theta_o        (theta_o),
    .quarter_o      (quarter_o),
    .valid_o        (valid_o)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_i = 1'b0;
    phase_clr_i = 1'b0;
    freq_load_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_inc(input logic [31:0] w);
    freq_word_i = w;
    freq_load_i = 1'b1;
    tick();
    freq_load_i = 1'b0;
  endtask

  // n RUN cycles; optional phase clear sampled at the end of RUN cycle clr_at+1
  task automatic run_burst(input int n, input int clr_at);
    run_i = 1'b1;
    for (int i = 0; i <= n + 2; i++) begin
      tick();
      phase_clr_i = (i == clr_at);
      if (i == n - 1) run_i = 1'b0;
      if (i < 2) begin
        check_vec("valid_lead", valid_o, 0);
      end else if (i < n + 2) begin
        check_vec("valid", valid_o, 1);
        check_vec("quarter", quarter_o, exp_q[i-2]);
        check_vec("theta", theta_o, exp_t[i-2]);
        check_vec("x", x_o, amp_i);
      end else begin
        check_vec("valid_tail", valid_o, 0);
        check_vec("quarter_hold", quarter_o, exp_q[n-1]);
        check_vec("theta_hold", theta_o, exp_t[n-1]);
      end
    end
    phase_clr_i = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    check_vec("rst_valid", valid_o, 0);
    check_vec("rst_x", x_o, 0);
    check_vec("rst_theta", theta_o, 0);
    check_vec("rst_quarter", quarter_o, 0);

    // quarter-turn steps
    load_inc(32'h4000_0000);
    amp_i = 13'sd123;
    exp_q = '{0, 1, 2, 3, 0, 0, 0, 0};
    exp_t = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_burst(5, -1);

    // eighth-turn steps
    do_reset();
    load_inc(32'h2000_0000);
    amp_i = -13'sd5;
    exp_q = '{0, 0, 1, 1, 2, 0, 0, 0};
    exp_t = '{0, 25736, 0, 25736, 0, 0, 0, 0};
    run_burst(5, -1);

    // wrap at full scale
    do_reset();
    phase_offset_i = 32'hFFFF_FFFF;
    phase_clr_i = 1'b1;
    load_inc(32'h0000_0001);
    phase_clr_i = 1'b0;
    amp_i = 13'sd4095;
    exp_q = '{3, 0, 0, 0, 0, 0, 0, 0};
    exp_t = '{51471, 0, 0, 0, 0, 0, 0, 0};
    run_burst(2, -1);

    // clear coincident with accumulate: acc jumps to offset, no increment
    do_reset();
    load_inc(32'h1000_0000);
    phase_offset_i = 32'hC000_0000;
    amp_i = 13'sd77;
    exp_q = '{0, 0, 3, 3, 3, 0, 0, 0};
    exp_t = '{0, 12868, 0, 12868, 25736, 0, 0, 0};
    run_burst(5, 1);

    // run dropped after 3 cycles
    do_reset();
    load_inc(32'h4000_0000);
    amp_i = 13'sd9;
    exp_q = '{0, 1, 2, 0, 0, 0, 0, 0};
    exp_t = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_burst(3, -1);
    tick();
    check_vec("valid_idle", valid_o, 0);
    check_vec("quarter_idle", quarter_o, 2);

    // reset mid-run
    do_reset();
    load_inc(32'h4000_0000);
    amp_i = 13'sd55;
    run_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_vec("pre_rst_quarter", quarter_o, 1);
    check_vec("pre_rst_x", x_o, 55);
    rst = 1'b1;
    run_i = 1'b0;
    tick();
    check_vec("midrst_valid", valid_o, 0);
    check_vec("midrst_x", x_o, 0);
    check_vec("midrst_theta", theta_o, 0);
    check_vec("midrst_quarter", quarter_o, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("post_rst_valid", valid_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
